// File: rtl/cnn_pkg.sv
// Shared CNN front-end constants: default image geometry, kernel size and
// the 3x3 window element indices (k = r*3 + c).
package cnn_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned IMG_W       = 28;
  localparam int unsigned IMG_H       = 28;
  localparam int unsigned KERNEL_SIZE = 3;
  localparam int unsigned WIN_N       = KERNEL_SIZE * KERNEL_SIZE;

  localparam int unsigned WIN_TOP_LEFT  = 0;
  localparam int unsigned WIN_TOP_RIGHT = 2;
  localparam int unsigned WIN_MID_LEFT  = 3;
  localparam int unsigned WIN_CENTER    = 4;
  localparam int unsigned WIN_MID_RIGHT = 5;
  localparam int unsigned WIN_BOT_LEFT  = 6;
  localparam int unsigned WIN_NEWEST    = 8;

  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return r * KERNEL_SIZE + c;
  endfunction

endpackage

// File: rtl/line_delay.sv
// Fixed-depth shift delay with enable; one image row of pixel history.
// Storage is deliberately not reset so it can map onto plain RAM/SRL.
module line_delay #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 28
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DEPTH-1:0][DATA_W-1:0] sr;

  always_ff @(posedge clk) begin
    if (en) sr <= {sr[DEPTH-2:0], d};
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/line_buffer_3x3.sv
// Streaming 3x3 window generator over a raster-order pixel stream.
// Define LB_FRAME_DONE_EN to add the frame_done last-pixel pulse output.
module line_buffer_3x3
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = cnn_pkg::DATA_W,
  parameter int unsigned IMG_W  = cnn_pkg::IMG_W,
  parameter int unsigned IMG_H  = cnn_pkg::IMG_H
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [DATA_W-1:0]                in_data,
  output logic [cnn_pkg::WIN_N*DATA_W-1:0] win,
  output logic                             win_valid
`ifdef LB_FRAME_DONE_EN
  ,
  output logic                             frame_done
`endif
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0]                col;
  logic [ROW_W-1:0]                row;
  logic [WIN_N-1:0][DATA_W-1:0]    win_q;
  logic [DATA_W-1:0]               tap0;
  logic [DATA_W-1:0]               tap1;
  logic                            accept;
  logic                            last_col;
  logic                            last_row;
  logic                            window_pos;

  assign accept     = in_valid & ~flush;
  assign last_col   = (col == COL_W'(IMG_W - 1));
  assign last_row   = (row == ROW_W'(IMG_H - 1));
  // Row/col gating keeps windows off row boundaries and off stale prior-frame rows
  assign window_pos = (row >= ROW_W'(KERNEL_SIZE - 1)) && (col >= COL_W'(KERNEL_SIZE - 1));

  line_delay #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_delay0 (
    .clk (clk),
    .en  (accept),
    .d   (in_data),
    .q   (tap0)
  );

  line_delay #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_delay1 (
    .clk (clk),
    .en  (accept),
    .d   (tap0),
    .q   (tap1)
  );

  // Position counters, window shift register and window strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      win_q     <= '0;
      win_valid <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      if (flush) begin
        col <= '0;
        row <= '0;
      end else if (in_valid) begin
        win_valid <= window_pos;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
        win_q <= {in_data, win_q[WIN_NEWEST], win_q[WIN_NEWEST-1],
                  tap0,    win_q[WIN_MID_RIGHT], win_q[WIN_CENTER],
                  tap1,    win_q[WIN_TOP_RIGHT], win_q[WIN_TOP_LEFT+1]};
      end
    end
  end

  assign win = win_q;

`ifdef LB_FRAME_DONE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= accept & last_col & last_row;
  end
`endif

endmodule

// File: tb/tb_line_buffer_3x3.sv
// Randomized bench for line_buffer_3x3 against an image-array reference model.
// Build with LB_FRAME_DONE_EN defined to also check frame_done.
module tb_line_buffer_3x3;

  localparam int unsigned DW = 16;
  localparam int unsigned W  = 28;
  localparam int unsigned H  = 28;
  localparam int unsigned WW = 9 * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [WW-1:0] win;
  logic          win_valid;
`ifdef LB_FRAME_DONE_EN
  logic          frame_done;
`endif

  always #5 clk = ~clk;

  line_buffer_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .win        (win),
    .win_valid  (win_valid)
`ifdef LB_FRAME_DONE_EN
    ,
    .frame_done (frame_done)
`endif
  );

  int checks = 0;
  int errors = 0;

  int          img [H][W];
  int          mr, mc;
  logic [WW-1:0] last_exp;
  bit          hold_known;
  bit          ramp_mode;
  int          win_count;
  int          fd_count;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Window centred one pixel up-left of (r,c), built from the current frame image
  function automatic logic [WW-1:0] window_at(input int r, input int c);
    logic [WW-1:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[DW*(i*3+j) +: DW] = DW'(img[r-2+i][c-2+j]);
    return w;
  endfunction

  task automatic step(input bit v, input logic [DW-1:0] d, input bit f);
    bit            exp_valid = 1'b0;
    bit            exp_fd    = 1'b0;
    logic [WW-1:0] exp_win   = '0;
    in_valid = v;
    in_data  = d;
    flush    = f;
    @(posedge clk);
    #1;
    if (f) begin
      mr = 0;
      mc = 0;
    end else if (v) begin
      img[mr][mc] = int'(d);
      exp_valid   = (mr >= 2) && (mc >= 2);
      exp_fd      = (mr == H-1) && (mc == W-1);
      if (exp_valid) exp_win = window_at(mr, mc);
      hold_known = exp_valid;
      last_exp   = exp_win;
      if (mc == W-1) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
    check("win_valid", WW'(win_valid), WW'(exp_valid));
    if (win_valid) win_count++;
    if (exp_valid) check("win", win, exp_win);
    else if (!(v && !f) && hold_known) check("win_hold", win, last_exp);
`ifdef LB_FRAME_DONE_EN
    check("frame_done", WW'(frame_done), WW'(exp_fd));
    if (frame_done && ramp_mode) begin
      fd_count++;
      check("frame_done_k8", WW'(win[8*DW +: DW]), WW'(783));
    end
`endif
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    flush    = 1'b0;
    in_data  = DW'($urandom);
    #1;
    check("reset_win", win, '0);
    check("reset_win_valid", WW'(win_valid), '0);
`ifdef LB_FRAME_DONE_EN
    check("reset_frame_done", WW'(frame_done), '0);
`endif
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold_win", win, '0);
      check("reset_hold_valid", WW'(win_valid), '0);
    end
    reset      = 1'b0;
    in_valid   = 1'b0;
    mr         = 0;
    mc         = 0;
    hold_known = 1'b1;
    last_exp   = '0;
  endtask

  task automatic frame(input int n, input int gap_pct, input bit rnd);
    ramp_mode = !rnd;
    for (int p = 0; p < n; p++) begin
      if (int'($urandom_range(99)) < gap_pct)
        repeat ($urandom_range(2, 1)) step(1'b0, DW'($urandom), 1'b0);
      step(1'b1, rnd ? DW'($urandom) : DW'(p), 1'b0);
      if (!rnd && p == 58) begin
        check("first_k8", WW'(win[8*DW +: DW]), WW'(58));
        check("first_k4", WW'(win[4*DW +: DW]), WW'(29));
        check("first_k0", WW'(win[0 +: DW]), WW'(0));
      end
      if (!rnd && p == W*H-1) check("last_k8", WW'(win[8*DW +: DW]), WW'(783));
    end
  endtask

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    fd_count = 0;
    do_reset();

    win_count = 0;
    frame(W*H, 0, 1'b0);
    check("count_continuous", WW'(win_count), WW'(676));

    win_count = 0;
    frame(W*H, 50, 1'b0);
    check("count_gaps", WW'(win_count), WW'(676));

    win_count = 0;
    frame(W*H, 10, 1'b1);
    check("count_random_data", WW'(win_count), WW'(676));

    frame(301, 0, 1'b0);
    do_reset();
    win_count = 0;
    frame(W*H, 0, 1'b0);
    check("count_after_reset", WW'(win_count), WW'(676));

    frame(100, 0, 1'b0);
    step(1'b1, DW'(100), 1'b1);
    win_count = 0;
    frame(W*H, 20, 1'b0);
    check("count_after_flush", WW'(win_count), WW'(676));

    fd_count  = 0;
    win_count = 0;
    frame(W*H, 30, 1'b0);
    frame(W*H, 30, 1'b0);
    check("count_two_frames", WW'(win_count), WW'(2*676));
`ifdef LB_FRAME_DONE_EN
    check("frame_done_count", WW'(fd_count), WW'(2));
`endif

    step(1'b0, '0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
